leaf_router_rr: RTL and testbench

- Parametrised next-generation leaf router for a group. Connects one GPU port to NUM_SPINES spine ports.
- Every input has its own FIFO. All ports use valid/ready backpressure.
- The GPU egress port has a round-robin arbiter. The block also provides a local loopback path, a misroute drop counter, and live FIFO status.
- It sits between a GPU endpoint and the spine layer, and replaces the fixed 4-spine, always-ready crossbar wrapper.

---
 rtl/leaf_router_pkg.sv | 24 ++
 rtl/router_fifo.sv | 44 ++++
 rtl/leaf_router_rr.sv | 201 ++++++++++++++++++++
 tb/tb_leaf_router_rr.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_router_pkg.sv
// Shared address-field layout and routing helpers for the leaf router.
package leaf_router_pkg;

    localparam int unsigned ADDR_MAX = 32;
    localparam int unsigned DEF_AWIDTH = 6;

    localparam int unsigned LEAF_LSB = 0;
    localparam int unsigned LEAF_MSB = 1;
    localparam int unsigned GRP_LSB  = 2;
    localparam int unsigned GRP_MSB  = DEF_AWIDTH - 1;

    // Callers zero-extend dest and group, so everything above the leaf field is the group.
    function automatic logic is_local(input logic [ADDR_MAX-1:0] dest,
                                      input logic [ADDR_MAX-1:0] group,
                                      input logic [1:0]          leaf);
        return ((dest >> GRP_LSB) == group) && (dest[LEAF_MSB:LEAF_LSB] == leaf);
    endfunction

    function automatic int unsigned spine_sel(input logic [ADDR_MAX-1:0] dest,
                                              input int unsigned         n);
        return dest % n;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// Pointer-based synchronous FIFO; the extra pointer bit separates full from empty.
module router_fifo #(
    parameter int unsigned WIDTH = 22,
    parameter int unsigned DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_word,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_word,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign o_rd_word = r_mem[r_rd_ptr[PW-1:0]];
    assign w_do_wr   = i_wr_en && !o_full;
    assign w_do_rd   = i_rd_en && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[PW-1:0]] <= i_wr_word;
    end

endmodule

// File: rtl/leaf_router_rr.sv
// Leaf router: one GPU port and NUM_SPINES spine ports, per-input FIFOs,
// round-robin GPU egress arbitration, loopback and misroute drop counting.
module leaf_router_rr
    import leaf_router_pkg::*;
#(
    parameter int unsigned        DWIDTH     = 16,
    parameter int unsigned        AWIDTH     = 6,
    parameter int unsigned        NUM_SPINES = 4,
    parameter int unsigned        FIFO_DEPTH = 8,
    parameter logic [AWIDTH-3:0]  GROUP_ID   = 4'b0010,
    parameter logic [1:0]         LEAF_ID    = 2'd1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              arb_enable,
    input  logic [DWIDTH-1:0]                 gpu_in_data,
    input  logic [AWIDTH-1:0]                 gpu_in_dest,
    input  logic                              gpu_in_valid,
    output logic                              gpu_in_ready,
    output logic [DWIDTH-1:0]                 gpu_out_data,
    output logic                              gpu_out_valid,
    input  logic                              gpu_out_ready,
    input  logic [NUM_SPINES*DWIDTH-1:0]      spine_in_data,
    input  logic [NUM_SPINES*AWIDTH-1:0]      spine_in_dest,
    input  logic [NUM_SPINES-1:0]             spine_in_valid,
    output logic [NUM_SPINES-1:0]             spine_in_ready,
    output logic [NUM_SPINES*DWIDTH-1:0]      spine_out_data,
    output logic [NUM_SPINES*AWIDTH-1:0]      spine_out_dest,
    output logic [NUM_SPINES-1:0]             spine_out_valid,
    input  logic [NUM_SPINES-1:0]             spine_out_ready,
    output logic [NUM_SPINES:0]               fifo_full,
    output logic [NUM_SPINES:0]               fifo_empty,
    output logic [7:0]                        drop_count,
    output logic [$clog2(NUM_SPINES+1)-1:0]   current_grant,
    output logic                              busy
);

    localparam int unsigned NP = NUM_SPINES + 1;
    localparam int unsigned GW = $clog2(NP);
    localparam int unsigned FW = AWIDTH + DWIDTH;

    logic [FW-1:0]            w_wr_word [NP];
    logic [FW-1:0]            w_head    [NP];
    logic [NP-1:0]            w_wr_en;
    logic [NP-1:0]            w_rd_en;
    logic [NP-1:0]            w_full;
    logic [NP-1:0]            w_empty;
    logic [NP-1:0]            w_req;
    logic [NUM_SPINES-1:0]    w_up_load;
    logic [3:0]               w_drop_sum;
    logic [8:0]               w_drop_next;
    logic                     w_grant;
    logic [GW-1:0]            w_grant_idx;
    logic [DWIDTH-1:0]        w_grant_data;
    logic [GW:0]              w_sum;
    logic [AWIDTH-1:0]        w_gpu_dest;
    logic [DWIDTH-1:0]        w_gpu_data;

    logic                          r_gpu_valid;
    logic [DWIDTH-1:0]             r_gpu_data;
    logic [NUM_SPINES-1:0]         r_sp_valid;
    logic [NUM_SPINES*DWIDTH-1:0]  r_sp_data;
    logic [NUM_SPINES*AWIDTH-1:0]  r_sp_dest;
    logic [GW-1:0]                 r_ptr;
    logic [7:0]                    r_drop;

    always_comb begin
        for (int unsigned i = 0; i < NUM_SPINES; i++) begin
            w_wr_word[i] = {spine_in_dest[i*AWIDTH +: AWIDTH], spine_in_data[i*DWIDTH +: DWIDTH]};
            w_wr_en[i]   = spine_in_valid[i] & spine_in_ready[i];
        end
        w_wr_word[NUM_SPINES] = {gpu_in_dest, gpu_in_data};
        w_wr_en[NUM_SPINES]   = gpu_in_valid & gpu_in_ready;
    end

    for (genvar gi = 0; gi < NP; gi++) begin : g_fifo
        router_fifo #(
            .WIDTH (FW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk     (clk),
            .i_rst_n   (reset),
            .i_wr_en   (w_wr_en[gi]),
            .i_wr_word (w_wr_word[gi]),
            .i_rd_en   (w_rd_en[gi]),
            .o_rd_word (w_head[gi]),
            .o_full    (w_full[gi]),
            .o_empty   (w_empty[gi])
        );
    end

    // Ready is forced low while reset is held.
    assign spine_in_ready = ~w_full[NUM_SPINES-1:0] & {NUM_SPINES{reset}};
    assign gpu_in_ready   = ~w_full[NUM_SPINES] & reset;

    assign w_gpu_dest = w_head[NUM_SPINES][FW-1 -: AWIDTH];
    assign w_gpu_data = w_head[NUM_SPINES][DWIDTH-1:0];

    always_comb begin
        w_req        = '0;
        w_rd_en      = '0;
        w_up_load    = '0;
        w_drop_sum   = '0;
        w_grant      = 1'b0;
        w_grant_idx  = '0;
        w_grant_data = '0;
        w_sum        = '0;

        if (!w_empty[NUM_SPINES]) begin
            if (is_local(ADDR_MAX'(w_gpu_dest), ADDR_MAX'(GROUP_ID), LEAF_ID)) begin
                w_req[NUM_SPINES] = 1'b1;
            end else begin
                for (int unsigned s = 0; s < NUM_SPINES; s++) begin
                    if (spine_sel(ADDR_MAX'(w_gpu_dest), NUM_SPINES) == s && arb_enable &&
                        (!r_sp_valid[s] || spine_out_ready[s])) begin
                        w_up_load[s]        = 1'b1;
                        w_rd_en[NUM_SPINES] = 1'b1;
                    end
                end
            end
        end

        // Misrouted spine heads are discarded regardless of arb_enable.
        for (int unsigned i = 0; i < NUM_SPINES; i++) begin
            if (!w_empty[i]) begin
                if (is_local(ADDR_MAX'(w_head[i][FW-1 -: AWIDTH]), ADDR_MAX'(GROUP_ID), LEAF_ID)) begin
                    w_req[i] = 1'b1;
                end else begin
                    w_rd_en[i] = 1'b1;
                    w_drop_sum = w_drop_sum + 4'd1;
                end
            end
        end

        if (arb_enable && (!r_gpu_valid || gpu_out_ready)) begin
            for (int unsigned k = 1; k <= NP; k++) begin
                w_sum = {1'b0, r_ptr} + (GW+1)'(k);
                if (w_sum >= (GW+1)'(NP)) w_sum = w_sum - (GW+1)'(NP);
                for (int unsigned i = 0; i < NP; i++) begin
                    if (!w_grant && w_sum == (GW+1)'(i) && w_req[i]) begin
                        w_grant     = 1'b1;
                        w_grant_idx = GW'(i);
                    end
                end
            end
            for (int unsigned i = 0; i < NP; i++) begin
                if (w_grant && w_grant_idx == GW'(i)) begin
                    w_rd_en[i]   = 1'b1;
                    w_grant_data = w_head[i][DWIDTH-1:0];
                end
            end
        end
    end

    assign w_drop_next = {1'b0, r_drop} + 9'(w_drop_sum);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gpu_valid <= 1'b0;
            r_gpu_data  <= '0;
            r_sp_valid  <= '0;
            r_sp_data   <= '0;
            r_sp_dest   <= '0;
            r_ptr       <= '0;
            r_drop      <= '0;
        end else begin
            if (w_grant) begin
                r_gpu_valid <= 1'b1;
                r_gpu_data  <= w_grant_data;
                r_ptr       <= w_grant_idx;
            end else if (gpu_out_ready) begin
                r_gpu_valid <= 1'b0;
                r_gpu_data  <= '0;
            end
            for (int unsigned s = 0; s < NUM_SPINES; s++) begin
                if (w_up_load[s]) begin
                    r_sp_valid[s]                  <= 1'b1;
                    r_sp_data[s*DWIDTH +: DWIDTH]  <= w_gpu_data;
                    r_sp_dest[s*AWIDTH +: AWIDTH]  <= w_gpu_dest;
                end else if (spine_out_ready[s]) begin
                    r_sp_valid[s]                  <= 1'b0;
                    r_sp_data[s*DWIDTH +: DWIDTH]  <= '0;
                    r_sp_dest[s*AWIDTH +: AWIDTH]  <= '0;
                end
            end
            r_drop <= (w_drop_next > 9'd255) ? 8'hFF : w_drop_next[7:0];
        end
    end

    assign gpu_out_valid   = r_gpu_valid;
    assign gpu_out_data    = r_gpu_data;
    assign spine_out_valid = r_sp_valid;
    assign spine_out_data  = r_sp_data;
    assign spine_out_dest  = r_sp_dest;
    assign fifo_full       = w_full;
    assign fifo_empty      = w_empty;
    assign drop_count      = r_drop;
    assign current_grant   = r_ptr;
    assign busy            = ~&w_empty | r_gpu_valid | (|r_sp_valid);

endmodule

// File: tb/tb_leaf_router_rr.sv
// Directed bench for leaf_router_rr: reset, loopback, uplink backpressure,
// round-robin order, misroute saturation and arb_enable gating.
module tb_leaf_router_rr;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 6;
    localparam int unsigned NS = 4;

    logic            clk;
    logic            reset;
    logic            arb_enable;
    logic [DW-1:0]   gpu_in_data;
    logic [AW-1:0]   gpu_in_dest;
    logic            gpu_in_valid;
    logic            gpu_in_ready;
    logic [DW-1:0]   gpu_out_data;
    logic            gpu_out_valid;
    logic            gpu_out_ready;
    logic [NS*DW-1:0] spine_in_data;
    logic [NS*AW-1:0] spine_in_dest;
    logic [NS-1:0]   spine_in_valid;
    logic [NS-1:0]   spine_in_ready;
    logic [NS*DW-1:0] spine_out_data;
    logic [NS*AW-1:0] spine_out_dest;
    logic [NS-1:0]   spine_out_valid;
    logic [NS-1:0]   spine_out_ready;
    logic [NS:0]     fifo_full;
    logic [NS:0]     fifo_empty;
    logic [7:0]      drop_count;
    logic [2:0]      current_grant;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    leaf_router_rr #(
        .DWIDTH     (DW),
        .AWIDTH     (AW),
        .NUM_SPINES (NS),
        .FIFO_DEPTH (8),
        .GROUP_ID   (4'b0010),
        .LEAF_ID    (2'd1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .arb_enable      (arb_enable),
        .gpu_in_data     (gpu_in_data),
        .gpu_in_dest     (gpu_in_dest),
        .gpu_in_valid    (gpu_in_valid),
        .gpu_in_ready    (gpu_in_ready),
        .gpu_out_data    (gpu_out_data),
        .gpu_out_valid   (gpu_out_valid),
        .gpu_out_ready   (gpu_out_ready),
        .spine_in_data   (spine_in_data),
        .spine_in_dest   (spine_in_dest),
        .spine_in_valid  (spine_in_valid),
        .spine_in_ready  (spine_in_ready),
        .spine_out_data  (spine_out_data),
        .spine_out_dest  (spine_out_dest),
        .spine_out_valid (spine_out_valid),
        .spine_out_ready (spine_out_ready),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .drop_count      (drop_count),
        .current_grant   (current_grant),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [DW-1:0] exp_data [6];
    logic [2:0]    exp_gnt  [6];
    logic [DW-1:0] gate_data [4];
    int            seen;
    int            ok_cnt;

    initial begin
        reset           = 1'b0;
        arb_enable      = 1'b1;
        gpu_in_data     = '0;
        gpu_in_dest     = '0;
        gpu_in_valid    = 1'b0;
        gpu_out_ready   = 1'b1;
        spine_in_data   = '0;
        spine_in_dest   = '0;
        spine_in_valid  = '0;
        spine_out_ready = '1;

        // Reset and idle
        step(3);
        chk("rst_gpu_in_ready", gpu_in_ready, 0);
        chk("rst_spine_in_ready", spine_in_ready, 0);
        chk("rst_fifo_empty", fifo_empty, 5'b11111);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_valids", {gpu_out_valid, spine_out_valid}, 0);
        chk("rst_grant", current_grant, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        step(1);
        chk("rel_gpu_in_ready", gpu_in_ready, 1);
        chk("rel_spine_in_ready", spine_in_ready, 4'hF);

        // Loopback
        gpu_in_data  = 16'hA5A5;
        gpu_in_dest  = 6'b0010_01;
        gpu_in_valid = 1'b1;
        step(1);
        gpu_in_valid = 1'b0;
        chk("lb_valid_cycle1", gpu_out_valid, 0);
        step(1);
        chk("lb_valid_cycle2", gpu_out_valid, 1);
        chk("lb_data", gpu_out_data, 16'hA5A5);
        chk("lb_no_spine", spine_out_valid, 0);
        chk("lb_grant", current_grant, 4);
        step(1);
        chk("lb_cleared", gpu_out_valid, 0);
        chk("lb_idle", busy, 0);

        // Uplink with spine 2 stalled
        spine_out_ready = 4'b1011;
        for (int w = 0; w < 9; w++) begin
            chk("up_in_ready", gpu_in_ready, 1);
            gpu_in_data  = 16'h1000 + 16'(w);
            gpu_in_dest  = 6'b0011_10;
            gpu_in_valid = 1'b1;
            step(1);
        end
        gpu_in_valid = 1'b0;
        chk("up_full_ready", gpu_in_ready, 0);
        chk("up_fifo_full", fifo_full, 5'b10000);
        chk("up_sp_valid", spine_out_valid, 4'b0100);
        step(2);
        chk("up_hold_data", spine_out_data[2*DW +: DW], 16'h1000);
        chk("up_hold_dest", spine_out_dest[2*AW +: AW], 6'b0011_10);
        spine_out_ready = 4'b1111;
        for (int w = 0; w < 9; w++) begin
            chk("up_drain_valid", spine_out_valid, 4'b0100);
            chk("up_drain_data", spine_out_data[2*DW +: DW], 16'h1000 + 16'(w));
            step(1);
        end
        chk("up_done_valid", spine_out_valid, 0);
        chk("up_done_empty", fifo_empty, 5'b11111);
        chk("up_no_gpu_out", gpu_out_valid, 0);

        // Asynchronous reset while a word sits in the egress register
        gpu_out_ready = 1'b0;
        gpu_in_data   = 16'h5A5A;
        gpu_in_dest   = 6'b0010_01;
        gpu_in_valid  = 1'b1;
        step(1);
        gpu_in_valid = 1'b0;
        step(2);
        chk("ar_pre_valid", gpu_out_valid, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_async_valid", gpu_out_valid, 0);
        chk("ar_async_empty", fifo_empty, 5'b11111);
        step(1);
        reset = 1'b1;
        gpu_out_ready = 1'b1;
        step(1);
        chk("ar_post_valid", gpu_out_valid, 0);

        // Round-robin: spines 0, 1, 3 each send two local words
        exp_data[0] = 16'h0100; exp_gnt[0] = 3'd1;
        exp_data[1] = 16'h0300; exp_gnt[1] = 3'd3;
        exp_data[2] = 16'h0000; exp_gnt[2] = 3'd0;
        exp_data[3] = 16'h0101; exp_gnt[3] = 3'd1;
        exp_data[4] = 16'h0301; exp_gnt[4] = 3'd3;
        exp_data[5] = 16'h0001; exp_gnt[5] = 3'd0;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NS; i++) begin
                spine_in_data[i*DW +: DW] = 16'(16'h0100 * i + j);
                spine_in_dest[i*AW +: AW] = 6'b0010_01;
            end
            spine_in_valid = 4'b1011;
            step(1);
        end
        spine_in_valid = '0;
        for (int k = 0; k < 6; k++) begin
            chk("rr_valid", gpu_out_valid, 1);
            chk("rr_data", gpu_out_data, exp_data[k]);
            chk("rr_grant", current_grant, exp_gnt[k]);
            step(1);
        end
        chk("rr_done", gpu_out_valid, 0);

        // Misroute drops, first 100 with arb_enable low
        arb_enable = 1'b0;
        seen = 0;
        ok_cnt = 0;
        spine_in_dest[2*AW +: AW] = 6'b0101_00;
        for (int w = 0; w < 300; w++) begin
            if (w == 100) begin
                spine_in_valid = '0;
                step(2);
                chk("mr_count_100", drop_count, 100);
                arb_enable = 1'b1;
            end
            if (spine_in_ready[2]) ok_cnt++;
            spine_in_data[2*DW +: DW] = 16'(w);
            spine_in_valid = 4'b0100;
            step(1);
            if (gpu_out_valid) seen++;
        end
        spine_in_valid = '0;
        step(2);
        chk("mr_ready_always", ok_cnt, 300);
        chk("mr_no_gpu_out", seen, 0);
        chk("mr_saturated", drop_count, 255);
        chk("mr_empty", fifo_empty, 5'b11111);

        // arb_enable gating with four local words queued
        arb_enable = 1'b0;
        for (int j = 0; j < 2; j++) begin
            spine_in_data[0*DW +: DW] = 16'hC000 + 16'(j);
            spine_in_data[1*DW +: DW] = 16'hC100 + 16'(j);
            spine_in_dest[0*AW +: AW] = 6'b0010_01;
            spine_in_dest[1*AW +: AW] = 6'b0010_01;
            spine_in_valid = 4'b0011;
            step(1);
        end
        spine_in_valid = '0;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            if (gpu_out_valid) seen++;
        end
        chk("gate_no_grant", seen, 0);
        chk("gate_queued", fifo_empty, 5'b11100);
        gate_data[0] = 16'hC100;
        gate_data[1] = 16'hC000;
        gate_data[2] = 16'hC101;
        gate_data[3] = 16'hC001;
        arb_enable = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            if (gpu_out_valid) seen++;
            chk("gate_drain_data", gpu_out_data, gate_data[k]);
        end
        chk("gate_drained", seen, 4);
        chk("gate_empty", fifo_empty, 5'b11111);
        step(1);
        chk("gate_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
